// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - frame-buffer arbiter: scan-out reads with priority, writer in free cycles, double-buffered pages
module vram_arbiter #(
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int OFS_W       = 17,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic              vsync,
    input  logic              wr_req,
    input  logic [OFS_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_page,
    output logic              ram_en,
    output logic              ram_we,
    output logic [OFS_W:0]    ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] pix_data
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    if (FB_W * FB_H > (1 << OFS_W)) begin : g_cfg_check
        $error("vram_arbiter: FB_W*FB_H does not fit in one page");
    end

    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [OFS_W:0]    addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              rd1_q, rd2_q, blk1_q, blk2_q;
    logic              front_q, front_d;
    logic              done_q, done_d;
    logic [0:0]        state_q, state_d;
    logic              vsync_q;

    logic              disp_slot;
    logic              blank_slot;
    logic              frame_edge;
    logic [OFS_W-1:0]  disp_off;

    assign disp_slot  = p_tick & video_on;
    assign blank_slot = p_tick & ~video_on;
    assign frame_edge = vsync & ~vsync_q;
    assign disp_off   = OFS_W'(32'(pixel_y >> SCALE_SHIFT) * 32'(FB_W)
                               + 32'(pixel_x >> SCALE_SHIFT));

    always_comb begin
        wr_ack = ~reset & ~disp_slot & wr_req;
        en_d   = 1'b0;
        we_d   = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        if (disp_slot) begin
            en_d   = 1'b1;
            addr_d = {front_q, disp_off};
        end else if (wr_req) begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            addr_d = {~front_q, wr_addr};
            din_d  = wr_data;
        end

        // RAM data arrives two cycles after the slot; blank slots zero the pixel at the same point
        pix_d = pix_q;
        if (rd2_q) begin
            pix_d = ram_dout;
        end else if (blk2_q) begin
            pix_d = '0;
        end

        state_d = state_q;
        front_d = front_q;
        done_d  = 1'b0;
        if (frame_edge && (state_q == PENDING || swap_req)) begin
            front_d = ~front_q;
            done_d  = 1'b1;
            state_d = IDLE;
        end else if (swap_req) begin
            state_d = PENDING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            pix_q   <= '0;
            rd1_q   <= 1'b0;
            rd2_q   <= 1'b0;
            blk1_q  <= 1'b0;
            blk2_q  <= 1'b0;
            front_q <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
            vsync_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            pix_q   <= pix_d;
            rd1_q   <= disp_slot;
            rd2_q   <= rd1_q;
            blk1_q  <= blank_slot;
            blk2_q  <= blk1_q;
            front_q <= front_d;
            done_q  <= done_d;
            state_q <= state_d;
            vsync_q <= vsync;
        end
    end

    assign ram_en     = en_q;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_din    = din_q;
    assign pix_data   = pix_q;
    assign front_page = front_q;
    assign swap_done  = done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - vector, directed and randomized checks of vram_arbiter against a transaction model
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        p_tick, video_on, vsync;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        swap_req, swap_done, front_page;
    logic        ram_en, ram_we;
    logic [17:0] ram_addr;
    logic [11:0] ram_din;
    logic [11:0] ram_dout = '0;
    logic [11:0] pix_data;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .p_tick(p_tick), .video_on(video_on), .vsync(vsync),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .swap_req(swap_req), .swap_done(swap_done), .front_page(front_page),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .pix_data(pix_data)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one cycle of read latency
    logic [11:0] tb_ram [0:262143];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] = ram_din;
            else ram_dout <= tb_ram[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    // Transaction-level reference: picture memory plus expected outputs for the next cycle
    typedef struct { int due; logic [11:0] val; } pe_t;
    pe_t         pq[$];
    logic [11:0] m_mem [0:262143];
    logic        m_en, m_we, m_front, m_done, m_pending, m_vs_prev, m_ack;
    logic [17:0] m_addr;
    logic [11:0] m_din, m_pix;

    task automatic model_cycle();
        int off;
        bit edge_seen;
        m_ack = !reset && !(p_tick && video_on) && wr_req;
        chk("wr_ack", 32'(wr_ack), 32'(m_ack));
        if (reset) begin
            m_en = 0; m_we = 0; m_addr = 0; m_din = 0; m_pix = 0;
            m_front = 0; m_pending = 0; m_done = 0; m_vs_prev = 0;
            pq.delete();
        end else begin
            off = ((int'(pixel_y) / 2) * 320 + int'(pixel_x) / 2) % 131072;
            if (p_tick && video_on) begin
                m_en = 1; m_we = 0;
                m_addr = 18'(int'(m_front) * 131072 + off);
                pq.push_back('{cyc_n + 3, m_mem[m_addr]});
            end else if (wr_req) begin
                m_en = 1; m_we = 1;
                m_addr = 18'(int'(!m_front) * 131072 + int'(wr_addr));
                m_din = wr_data;
                m_mem[m_addr] = wr_data;
            end else begin
                m_en = 0; m_we = 0;
            end
            if (p_tick && !video_on) pq.push_back('{cyc_n + 3, 12'h000});
            edge_seen = vsync && !m_vs_prev;
            m_vs_prev = vsync;
            m_done = 0;
            if (edge_seen && (m_pending || swap_req)) begin
                m_front = !m_front; m_done = 1; m_pending = 0;
            end else if (swap_req) begin
                m_pending = 1;
            end
        end
    endtask

    task automatic check_outputs();
        pe_t e;
        while (pq.size() > 0 && pq[0].due == cyc_n) begin
            e = pq.pop_front();
            m_pix = e.val;
        end
        chk("ram_en",     32'(ram_en),     32'(m_en));
        chk("ram_we",     32'(ram_we),     32'(m_we));
        chk("ram_addr",   32'(ram_addr),   32'(m_addr));
        chk("ram_din",    32'(ram_din),    32'(m_din));
        chk("pix_data",   32'(pix_data),   32'(m_pix));
        chk("front_page", 32'(front_page), 32'(m_front));
        chk("swap_done",  32'(swap_done),  32'(m_done));
    endtask

    task automatic step();
        #1;
        model_cycle();
        @(posedge clk);
        #1;
        cyc_n++;
        check_outputs();
    endtask

    task automatic idle_inputs();
        reset = 0; p_tick = 0; video_on = 0; wr_req = 0; swap_req = 0;
    endtask

    typedef struct { int x; int y; int addr; logic [11:0] pix; } vec_t;
    vec_t tbl [6];

    int pulses;
    int ph;

    initial begin
        tbl[0] = '{0,   0,   0,     12'h111};
        tbl[1] = '{1,   1,   0,     12'h111};
        tbl[2] = '{2,   0,   1,     12'h222};
        tbl[3] = '{0,   2,   320,   12'h333};
        tbl[4] = '{20,  10,  1610,  12'hABC};
        tbl[5] = '{639, 479, 76799, 12'hFED};

        for (int i = 0; i < 262144; i++) begin
            tb_ram[i] = '0;
            m_mem[i]  = '0;
        end
        for (int i = 0; i < 6; i++) begin
            tb_ram[tbl[i].addr] = tbl[i].pix;
            m_mem[tbl[i].addr]  = tbl[i].pix;
        end
        m_en = 0; m_we = 0; m_addr = 0; m_din = 0; m_pix = 0;
        m_front = 0; m_done = 0; m_pending = 0; m_vs_prev = 0; m_ack = 0;

        idle_inputs();
        reset = 1; vsync = 0; pixel_x = 0; pixel_y = 0; wr_addr = 0; wr_data = 0;
        @(posedge clk);
        #1;
        step();
        step();

        // Idle after reset
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("idle_ram_en", 32'(ram_en), 32'd0);
            chk("idle_pix", 32'(pix_data), 32'd0);
            chk("idle_front", 32'(front_page), 32'd0);
        end

        // Address-generation vectors
        for (int i = 0; i < 6; i++) begin
            pixel_x = 10'(tbl[i].x); pixel_y = 10'(tbl[i].y);
            video_on = 1; p_tick = 1;
            step();
            p_tick = 0;
            chk("vec_addr", 32'(ram_addr), 32'(tbl[i].addr));
            chk("vec_we", 32'(ram_we), 32'd0);
            step();
            step();
            chk("vec_pix", 32'(pix_data), 32'(tbl[i].pix));
        end

        // Writer held against display slots
        wr_req = 1; wr_addr = 17'd100; wr_data = 12'h0F0; video_on = 1;
        for (int i = 0; i < 12; i++) begin
            p_tick = (i % 4 == 0);
            step();
            chk("ilv_ack", 32'(wr_ack), 32'(i % 4 != 0));
            if (i % 4 != 0) begin
                chk("ilv_wr_addr", 32'(ram_addr), 32'(131072 + 100));
                chk("ilv_wr_din", 32'(ram_din), 32'h0F0);
            end
            chk("ilv_we", 32'(ram_we), 32'(i % 4 != 0));
        end
        idle_inputs();
        step();

        // Swap requested mid-frame waits for the vsync edge
        swap_req = 1;
        step();
        swap_req = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("swap_wait_front", 32'(front_page), 32'd0);
            chk("swap_wait_done", 32'(swap_done), 32'd0);
        end
        vsync = 1;
        step();
        chk("swap_front", 32'(front_page), 32'd1);
        chk("swap_done", 32'(swap_done), 32'd1);
        step();
        chk("swap_done_once", 32'(swap_done), 32'd0);
        wr_req = 1; wr_addr = 17'd5; wr_data = 12'h123;
        step();
        wr_req = 0;
        chk("swap_wr_page", 32'(ram_addr), 32'd5);
        video_on = 1; p_tick = 1; pixel_x = 0; pixel_y = 0;
        step();
        p_tick = 0;
        chk("swap_rd_page", 32'(ram_addr), 32'h20000);
        step();
        step();
        vsync = 0;
        step();

        // Swap coincident with the edge, then a double request while pending
        swap_req = 1; vsync = 1;
        step();
        swap_req = 0;
        chk("coinc_front", 32'(front_page), 32'd0);
        chk("coinc_done", 32'(swap_done), 32'd1);
        step();
        chk("coinc_done_once", 32'(swap_done), 32'd0);
        vsync = 0;
        step();
        swap_req = 1; step();
        swap_req = 0; step();
        swap_req = 1; step();
        swap_req = 0; step();
        vsync = 1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (swap_done) pulses++;
        end
        chk("double_req_pulses", 32'(pulses), 32'd1);
        chk("double_req_front", 32'(front_page), 32'd1);
        vsync = 0;
        step();

        // Reset during a write accept with a display fetch in flight and a swap pending
        tb_ram[131072 + 1610] = 12'h9A5;
        m_mem[131072 + 1610]  = 12'h9A5;
        swap_req = 1; video_on = 1; p_tick = 1; pixel_x = 20; pixel_y = 10;
        step();
        swap_req = 0; p_tick = 0; wr_req = 1; wr_addr = 17'd7; wr_data = 12'h456;
        step();
        reset = 1;
        step();
        reset = 0; wr_req = 0;
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_pix", 32'(pix_data), 32'd0);
        chk("rst_front", 32'(front_page), 32'd0);
        step();
        chk("rst_pix_late", 32'(pix_data), 32'd0);
        vsync = 1;
        step();
        chk("rst_pending_lost", 32'(front_page), 32'd0);
        vsync = 0;
        step();

        // Randomized traffic against the model
        idle_inputs();
        ph = 0;
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            p_tick   = (ph == 0);
            ph       = (ph + 1) % 4;
            video_on = ($urandom_range(0, 3) != 0);
            pixel_x  = 10'($urandom_range(0, 15));
            pixel_y  = 10'($urandom_range(0, 7));
            if (!(wr_req && !m_ack)) begin
                wr_req  = 1'($urandom_range(0, 1));
                wr_addr = 17'($urandom_range(0, 3) * 320 + $urandom_range(0, 7));
                wr_data = 12'($urandom);
            end
            if ($urandom_range(0, 63) == 0) vsync = ~vsync;
            swap_req = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
